// File: rtl/world_time_counter.sv
// world_time_counter: 1 Hz prescaler plus UTC hh:mm:ss counters, set-mode field
// edits, and a registered time-zone-adjusted local hour for the display decoders.
// Optional 12-hour local display and PM flag: define WORLD_CLOCK_TWELVE_HOUR_EN.
module world_time_counter #(
  parameter int unsigned CLK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_mode,
  input  logic [1:0] set_field,
  input  logic       inc,
  input  logic       dec,
  input  logic [4:0] zone_offset,
  output logic [6:0] seconds,
  output logic [6:0] minutes,
  output logic [6:0] hours_utc,
  output logic [6:0] hours_local,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_wrap
);

  localparam int unsigned PresW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(CLK_HZ - 1);

  logic [PresW-1:0] presc_q, presc_d;
  logic [5:0]       sec_q, sec_d, min_q, min_d;
  logic [4:0]       hr_q, hr_d;
  logic             tick_q, tick_d, wrap_q, wrap_d;
  logic [4:0]       local_q, local_d;

  logic             sec_max, min_max, hr_max;

  assign sec_max = (sec_q == 6'd59);
  assign min_max = (min_q == 6'd59);
  assign hr_max  = (hr_q == 5'd23);

  // Prescaler, carry chain and set-mode edits; set_mode wins over run.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (set_mode) begin
      presc_d = '0;
      // Inc and dec together cancel; each field wraps within its own range.
      if (inc ^ dec) begin
        case (set_field)
          2'd0: sec_d = inc ? (sec_max ? 6'd0 : sec_q + 6'd1)
                            : ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1);
          2'd1: min_d = inc ? (min_max ? 6'd0 : min_q + 6'd1)
                            : ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1);
          2'd2: hr_d  = inc ? (hr_max ? 5'd0 : hr_q + 5'd1)
                            : ((hr_q == 5'd0) ? 5'd23 : hr_q - 5'd1);
          default: ;
        endcase
      end
    end else if (run) begin
      if (presc_q == PresMax) begin
        presc_d = '0;
        tick_d  = 1'b1;
        wrap_d  = sec_max && min_max && hr_max;
        sec_d   = sec_max ? 6'd0 : sec_q + 6'd1;
        if (sec_max) begin
          min_d = min_max ? 6'd0 : min_q + 6'd1;
          if (min_max) hr_d = hr_max ? 5'd0 : hr_q + 5'd1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  logic signed [4:0] zone_s;
  logic signed [5:0] off_c;
  logic signed [6:0] sum_c, adj_c;
  logic [4:0]        loc24_c;

  // Clamp the offset to -12..+14, then fold hours_utc + offset into 0..23.
  always_comb begin
    zone_s = signed'(zone_offset);
    if (zone_s < -5'sd12)     off_c = -6'sd12;
    else if (zone_s > 5'sd14) off_c = 6'sd14;
    else                      off_c = {zone_s[4], zone_s};
    sum_c = $signed({2'b00, hr_q}) + $signed({off_c[5], off_c});
    if (sum_c < 7'sd0)       adj_c = sum_c + 7'sd24;
    else if (sum_c > 7'sd23) adj_c = sum_c - 7'sd24;
    else                     adj_c = sum_c;
    loc24_c = adj_c[4:0];
  end

`ifdef WORLD_CLOCK_TWELVE_HOUR_EN
  logic pm_q, pm_d;

  // 12-hour display: 0 -> 12, 13..23 -> 1..11; PM for 12..23.
  always_comb begin
    if (loc24_c == 5'd0)       local_d = 5'd12;
    else if (loc24_c > 5'd12)  local_d = loc24_c - 5'd12;
    else                       local_d = loc24_c;
    pm_d = (loc24_c >= 5'd12);
  end

  // PM flag register, aligned with the local hour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pm_q <= 1'b0;
    else        pm_q <= pm_d;
  end

  assign pm = pm_q;
`else
  // 24-hour local display passes straight through.
  always_comb begin
    local_d = loc24_c;
  end

  assign pm = 1'b0;
`endif

  // State registers; reset clears everything, including in-flight pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      local_q <= '0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      local_q <= local_d;
    end
  end

  assign seconds     = {1'b0, sec_q};
  assign minutes     = {1'b0, min_q};
  assign hours_utc   = {2'b00, hr_q};
  assign hours_local = {2'b00, local_q};
  assign sec_tick    = tick_q;
  assign day_wrap    = wrap_q;

endmodule

// File: tb/tb_world_time_counter.sv
// Self-checking bench for world_time_counter: directed scenarios plus randomized
// stimulus against a time-of-day reference model kept as seconds-since-midnight.
module tb_world_time_counter;

  localparam int unsigned ClkHz = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       set_mode;
  logic [1:0] set_field;
  logic       inc;
  logic       dec;
  logic [4:0] zone_offset;
  logic [6:0] seconds, minutes, hours_utc, hours_local;
  logic       pm, sec_tick, day_wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_tod;
  int m_ph;
  int m_local;
  int m_pm;
  int m_tick;
  int m_wrap;

  world_time_counter #(.CLK_HZ(ClkHz)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .set_mode   (set_mode),
    .set_field  (set_field),
    .inc        (inc),
    .dec        (dec),
    .zone_offset(zone_offset),
    .seconds    (seconds),
    .minutes    (minutes),
    .hours_utc  (hours_utc),
    .hours_local(hours_local),
    .pm         (pm),
    .sec_tick   (sec_tick),
    .day_wrap   (day_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int local24(input int h, input logic [4:0] z);
    int off;
    off = $signed(z);
    if (off < -12) off = -12;
    if (off > 14) off = 14;
    return ((h + off) % 24 + 24) % 24;
  endfunction

  function automatic int disp_hour(input int l);
`ifdef WORLD_CLOCK_TWELVE_HOUR_EN
    if (l == 0) return 12;
    if (l > 12) return l - 12;
    return l;
`else
    return l;
`endif
  endfunction

  function automatic int pm_of(input int l);
`ifdef WORLD_CLOCK_TWELVE_HOUR_EN
    return (l >= 12) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_tod = 0; m_ph = 0; m_local = 0; m_pm = 0; m_tick = 0; m_wrap = 0;
  endtask

  // One rising edge of the reference, using the inputs as currently driven.
  task automatic model_update();
    int h, m, s, l, st;
    h = m_tod / 3600;
    m = (m_tod / 60) % 60;
    s = m_tod % 60;
    l = local24(h, zone_offset);
    m_local = disp_hour(l);
    m_pm = pm_of(l);
    m_tick = 0;
    m_wrap = 0;
    if (set_mode) begin
      m_ph = 0;
      if (inc != dec && set_field != 2'd3) begin
        st = inc ? 1 : -1;
        case (set_field)
          2'd0: s = (s + st + 60) % 60;
          2'd1: m = (m + st + 60) % 60;
          default: h = (h + st + 24) % 24;
        endcase
        m_tod = h * 3600 + m * 60 + s;
      end
    end else if (run) begin
      if (m_ph == ClkHz - 1) begin
        m_ph = 0;
        m_tick = 1;
        m_wrap = (m_tod == 86399) ? 1 : 0;
        m_tod = (m_tod + 1) % 86400;
      end else begin
        m_ph++;
      end
    end
  endtask

  task automatic compare_all();
    check("seconds", seconds, m_tod % 60);
    check("minutes", minutes, (m_tod / 60) % 60);
    check("hours_utc", hours_utc, m_tod / 3600);
    check("hours_local", hours_local, m_local);
    check("pm", pm, m_pm);
    check("sec_tick", sec_tick, m_tick);
    check("day_wrap", day_wrap, m_wrap);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic edit(input int f, input bit i, input bit d);
    set_field = f[1:0];
    inc = i;
    dec = d;
    step();
    inc = 1'b0;
    dec = 1'b0;
  endtask

  task automatic model_field(input int f, output int v);
    case (f)
      0: v = m_tod % 60;
      1: v = (m_tod / 60) % 60;
      default: v = m_tod / 3600;
    endcase
  endtask

  // Step a field upward in set mode until the model holds the target.
  task automatic set_to(input int f, input int target);
    int v;
    for (int k = 0; k < 60; k++) begin
      model_field(f, v);
      if (v == target) break;
      edit(f, 1'b1, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sec"}, seconds, 0);
    check({tag, "_min"}, minutes, 0);
    check({tag, "_hr"}, hours_utc, 0);
    check({tag, "_loc"}, hours_local, 0);
    check({tag, "_pm"}, pm, 0);
    check({tag, "_tick"}, sec_tick, 0);
    check({tag, "_wrap"}, day_wrap, 0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; set_mode = 1'b0; set_field = 2'd3;
    inc = 1'b0; dec = 1'b0; zone_offset = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    #2 rst_n = 1'b1;

    // Basic count: first second after 4 edges, second after 8.
    run = 1'b1;
    repeat (3) step();
    check("basic_s0", seconds, 0);
    step();
    check("basic_s1", seconds, 1);
    check("basic_tick", sec_tick, 1);
    step();
    check("basic_tick_off", sec_tick, 0);
    repeat (3) step();
    check("basic_s2", seconds, 2);

    // Day rollover from 23:59:59.
    set_mode = 1'b1;
    set_to(0, 59);
    edit(1, 1'b0, 1'b1);
    edit(2, 1'b0, 1'b1);
    check("set_hr23", hours_utc, 23);
    check("set_min59", minutes, 59);
    check("set_notick", sec_tick, 0);
    set_mode = 1'b0;
    repeat (3) step();
    check("roll_pre_sec", seconds, 59);
    check("roll_pre_hr", hours_utc, 23);
    step();
    check("roll_sec", seconds, 0);
    check("roll_min", minutes, 0);
    check("roll_hr", hours_utc, 0);
    check("roll_wrap", day_wrap, 1);
    step();
    check("roll_wrap_off", day_wrap, 0);

    // Zone arithmetic: UTC 3 with -5, then UTC 20 with +15 (clamped to +14).
    set_mode = 1'b1;
    set_to(2, 3);
    zone_offset = 5'b11011;
    step();
`ifdef WORLD_CLOCK_TWELVE_HOUR_EN
    check("zone_m5", hours_local, 10);
    check("zone_m5_pm", pm, 1);
`else
    check("zone_m5", hours_local, 22);
`endif
    set_to(2, 20);
    zone_offset = 5'd15;
    step();
    check("zone_p15", hours_local, 10);

    // Set-mode minute wrap in both directions, and inc+dec together.
    set_to(1, 59);
    edit(1, 1'b1, 1'b0);
    check("min_inc_wrap", minutes, 0);
    check("min_inc_hr", hours_utc, 20);
    edit(1, 1'b0, 1'b1);
    check("min_dec_wrap", minutes, 59);
    edit(1, 1'b1, 1'b1);
    check("min_both", minutes, 59);
    edit(3, 1'b1, 1'b0);
    check("field3", minutes, 59);

    // Local hours 0, 12 and 13 with zero offset.
    zone_offset = 5'd0;
    set_to(2, 0);
    step();
`ifdef WORLD_CLOCK_TWELVE_HOUR_EN
    check("h12_0", hours_local, 12);
`else
    check("h12_0", hours_local, 0);
`endif
    check("h12_0_pm", pm, 0);
    set_to(2, 12);
    step();
    check("h12_12", hours_local, 12);
`ifdef WORLD_CLOCK_TWELVE_HOUR_EN
    check("h12_12_pm", pm, 1);
`endif
    set_to(2, 13);
    step();
`ifdef WORLD_CLOCK_TWELVE_HOUR_EN
    check("h12_13", hours_local, 1);
    check("h12_13_pm", pm, 1);
`else
    check("h12_13", hours_local, 13);
`endif

    // Async reset halfway through a second at 10:20:30.
    set_to(2, 10);
    set_to(1, 20);
    set_to(0, 30);
    set_mode = 1'b0;
    run = 1'b1;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    check_all_zero("areset");
    model_reset();
    #2 rst_n = 1'b1;
    repeat (4) step();
    check("resume_s1", seconds, 1);
    check("resume_min", minutes, 0);

    // Randomized stimulus against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) set_mode = ~set_mode;
      if ($urandom_range(0, 24) == 0) run = ~run;
      if ($urandom_range(0, 29) == 0) zone_offset = 5'($urandom);
      set_field = 2'($urandom);
      inc = ($urandom_range(0, 2) == 0);
      dec = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
